// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction prefetch queue.
// Handshake: a transfer happens on a posedge where valid && ready; the producer holds its
// payload stable while valid is high and ready is low, and ready never depends on valid.
interface fetch_queue_if #(
  parameter int DEPTH = 4
) ();
  localparam int PTR_W = $clog2(DEPTH);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [31:0]      in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic [31:0]      out_pc_seq;
  logic [15:0]      out_imm16;
  logic [25:0]      out_addr26;
  logic [PTR_W:0]   count;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pc_seq, out_imm16, out_addr26, count
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_pc_seq, out_imm16, out_addr26, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of {pc, instr} pairs between fetch and decode, with pre-split
// head fields and a flush that empties the queue on a taken branch or jump.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  fetch_queue_if.slave   q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [63:0]      w_head;
  logic [31:0]      w_out_instr;
  logic [31:0]      w_out_pc;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

  // in_ready looks only at registered occupancy and flush, so decode cannot reach fetch combinationally.
  assign q.in_ready  = !w_full && !q.flush;
  assign q.out_valid = !w_empty;

  assign w_push = q.in_valid && q.in_ready;
  assign w_pop  = q.out_valid && q.out_ready;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_out_instr = w_empty ? 32'h0 : w_head[31:0];
  assign w_out_pc    = w_empty ? 32'h0 : w_head[63:32];

  assign q.out_instr  = w_out_instr;
  assign q.out_pc     = w_out_pc;
  assign q.out_pc_seq = w_empty ? 32'h0 : w_out_pc + 32'd4;
  assign q.out_imm16  = w_out_instr[15:0];
  assign q.out_addr26 = w_out_instr[25:0];
  assign q.count      = r_count;

  // Storage carries no reset; the empty gating hides stale contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {q.in_pc, q.in_instr};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || q.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, ordered drain with wrap, flush, steady
// streaming, reset-over-flush, and pc+4 wrap-around.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [63:0] exp_q[$];

  fetch_queue_if #(.DEPTH(DEPTH)) q ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge; inputs change and outputs settle 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                       input logic fl, input logic ordy);
    q.in_valid  = iv;
    q.in_pc     = pc;
    q.in_instr  = instr;
    q.flush     = fl;
    q.out_ready = ordy;
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h2008_0005 + {2'b00, pc[31:2]};
  endfunction

  task automatic check_head(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, {63'd0, q.out_valid}, 64'd1);
    check_eq({tag, "_pc"},    {32'd0, q.out_pc}, {32'd0, pc});
    check_eq({tag, "_instr"}, {32'd0, q.out_instr}, {32'd0, instr_of(pc)});
  endtask

  initial begin
    logic [31:0] next_pc;
    logic [31:0] prev_pc;
    logic [63:0] e;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 1: idle after reset
    check_eq("rst_valid",  {63'd0, q.out_valid}, 64'd0);
    check_eq("rst_instr",  {32'd0, q.out_instr}, 64'd0);
    check_eq("rst_pc",     {32'd0, q.out_pc}, 64'd0);
    check_eq("rst_pc_seq", {32'd0, q.out_pc_seq}, 64'd0);
    check_eq("rst_count",  {61'd0, q.count}, 64'd0);
    check_eq("rst_ready",  {63'd0, q.in_ready}, 64'd1);

    // 2: fill to full without popping
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'(4 * i), instr_of(32'(4 * i)), 1'b0, 1'b0);
      check_eq("fill_ready", {63'd0, q.in_ready}, 64'd1);
      tick();
      check_eq("fill_count", {61'd0, q.count}, 64'(i + 1));
    end
    check_eq("full_ready", {63'd0, q.in_ready}, 64'd0);
    check_head("full_head", 32'h0);
    check_eq("full_pc_seq", {32'd0, q.out_pc_seq}, 64'h4);
    drive(1'b1, 32'h10, instr_of(32'h10), 1'b0, 1'b0);
    tick();
    check_eq("held_count", {61'd0, q.count}, 64'd4);
    check_head("held_head", 32'h0);

    // 3: drain from full with fetch always valid; 14 pops wrap pointers 3+ times
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({32'(4 * i), instr_of(32'(4 * i))});
    next_pc = 32'h10;
    for (int c = 0; c < 14; c++) begin
      drive(1'b1, next_pc, instr_of(next_pc), 1'b0, 1'b1);
      if (c == 0) check_eq("stream_ready0", {63'd0, q.in_ready}, 64'd0);
      if (c == 1) check_eq("stream_ready1", {63'd0, q.in_ready}, 64'd1);
      if (c > 0)  check_eq("stream_count", {61'd0, q.count}, 64'd3);
      e = exp_q.pop_front();
      check_eq("stream_valid",  {63'd0, q.out_valid}, 64'd1);
      check_eq("stream_pc",     {32'd0, q.out_pc}, {32'd0, e[63:32]});
      check_eq("stream_instr",  {32'd0, q.out_instr}, {32'd0, e[31:0]});
      check_eq("stream_pc_seq", {32'd0, q.out_pc_seq}, {32'd0, e[63:32] + 32'd4});
      check_eq("stream_imm16",  {48'd0, q.out_imm16}, {48'd0, e[15:0]});
      check_eq("stream_addr26", {38'd0, q.out_addr26}, {38'd0, e[25:0]});
      if (c > 0) begin
        exp_q.push_back({next_pc, instr_of(next_pc)});
        next_pc = next_pc + 32'd4;
      end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    check_eq("pre_flush_count", {61'd0, q.count}, 64'd2);

    // 4: flush with push and pop both offered
    drive(1'b1, 32'h30, instr_of(32'h30), 1'b1, 1'b1);
    check_eq("flush_ready", {63'd0, q.in_ready}, 64'd0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_eq("flush_count", {61'd0, q.count}, 64'd0);
    check_eq("flush_valid", {63'd0, q.out_valid}, 64'd0);
    check_eq("flush_instr", {32'd0, q.out_instr}, 64'd0);
    drive(1'b1, 32'h40, instr_of(32'h40), 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_head("post_flush", 32'h40);
    check_eq("post_flush_count", {61'd0, q.count}, 64'd1);

    // 5: steady push+pop at count 1
    prev_pc = 32'h40;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'h44 + 32'(4 * k), instr_of(32'h44 + 32'(4 * k)), 1'b0, 1'b1);
      check_eq("steady_count", {61'd0, q.count}, 64'd1);
      check_head("steady_head", prev_pc);
      prev_pc = 32'h44 + 32'(4 * k);
      tick();
    end

    // 6: reset together with flush at count 3
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h80 + 32'(4 * k), instr_of(32'h80 + 32'(4 * k)), 1'b0, 1'b0);
      tick();
    end
    check_eq("pre_reset_count", {61'd0, q.count}, 64'd3);
    reset = 1'b1;
    drive(1'b1, 32'h90, instr_of(32'h90), 1'b1, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_eq("mid_rst_count",  {61'd0, q.count}, 64'd0);
    check_eq("mid_rst_valid",  {63'd0, q.out_valid}, 64'd0);
    check_eq("mid_rst_pc_seq", {32'd0, q.out_pc_seq}, 64'd0);
    check_eq("mid_rst_ready",  {63'd0, q.in_ready}, 64'd1);
    drive(1'b1, 32'h100, instr_of(32'h100), 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hFFFF_FFFC, instr_of(32'hFFFF_FFFC), 1'b0, 1'b1);
    check_head("after_rst", 32'h100);
    check_eq("after_rst_count", {61'd0, q.count}, 64'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_head("wrap", 32'hFFFF_FFFC);
    check_eq("wrap_pc_seq", {32'd0, q.out_pc_seq}, 64'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    check_eq("drained_count", {61'd0, q.count}, 64'd0);
    check_eq("drained_valid", {63'd0, q.out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction prefetch buffer between the instruction fetch unit and the decode/control stage of the pipelined MIPS datapath. It accepts {pc, instruction} pairs from fetch with a valid/ready handshake, stores them in a circular FIFO, and presents the oldest entry to decode with pre-extracted fields (imm16, addr26) and pc+4. A flush input discards all buffered instructions when a branch or jump is taken.

Parameters:
DEPTH, 4, number of entries; must be a power of two, at least 2
PTR_W, $clog2(DEPTH), read/write pointer width (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on posedge clk
reset  input  1  synchronous, active-high reset
flush  input  1  discard all entries this cycle (branch_taken from fetch)
in_valid  input  1  fetch presents a valid instruction
in_ready  output  1  queue can accept an entry this cycle
in_instr  input  32  fetched instruction word
in_pc  input  32  address of in_instr
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode consumes head this cycle
out_instr  output  32  head instruction; 32'h0 (nop) when empty
out_pc  output  32  head pc; 0 when empty
out_pc_seq  output  32  out_pc + 4; 0 when empty
out_imm16  output  16  out_instr[15:0]
out_addr26  output  26  out_instr[25:0]
count  output  PTR_W+1  number of valid entries, 0..DEPTH

Behaviour:
- Storage: DEPTH x 64-bit register array {pc, instr}; wr_ptr, rd_ptr PTR_W bits, wrap naturally modulo DEPTH; count tracks occupancy, which disambiguates full from empty.
- in_ready = (count != DEPTH) && !flush. Depends only on registered state and flush, never on out_ready, so there is no combinational path from decode to fetch.
- out_valid = (count != 0). Head outputs are driven combinationally from array[rd_ptr], gated to 0 when count == 0.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- Per posedge, in priority order:
  - reset: wr_ptr = rd_ptr = 0, count = 0. Array contents are don't-care, but outputs read 0 because of the gating.
  - flush: wr_ptr = rd_ptr = 0, count = 0. The in-flight push is dropped (in_ready is already 0) and any pop that cycle is ignored. The entry fetched in the cycle after flush is the first valid one.
  - Otherwise:
    - push only: write array[wr_ptr], wr_ptr+1, count+1.
    - pop only: rd_ptr+1, count-1.
    - push and pop together: both pointers advance, count unchanged. This is legal whenever 0 < count < DEPTH.
    - push and pop when empty: impossible, since out_valid is 0.
    - full: in_ready is 0, so no push occurs; a pop is still allowed, and in_ready returns the next cycle.
- Latency: an entry pushed at edge N is visible on out_* after edge N (first sampled by decode at edge N+1). There is no same-cycle bypass.
- Reset asserted mid-operation discards all contents, exactly as flush does. Reset takes priority over flush.
- out_pc_seq is a 32-bit add with wrap-around: 32'hFFFF_FFFC + 4 = 0.
- in_pc is not checked for alignment; it is stored as given.

Test Plan:
1. Reset, then idle → out_valid=0, out_instr=0, out_pc_seq=0, count=0, in_ready=1.
2. Push pc=0x00/0x04/0x08/0x0C with instr 0x2008_0005.. and out_ready=0 → count reaches 4 and in_ready=0. A 5th push with in_valid=1 is held and not written.
3. From full, out_ready=1 with in_valid=1 continuously → pops in order pc 0x00,0x04,..., out_pc_seq=out_pc+4, out_imm16=instr[15:0]. Pushes resume one cycle after the first pop. Run ≥3×DEPTH transfers to prove pointer wrap and FIFO ordering.
4. With count=2, assert flush together with in_valid=1 and out_ready=1 → next cycle count=0 and out_valid=0. The flushed-cycle push is never output. A push the following cycle (pc=0x40) appears as the head.
5. Steady push+pop each cycle with count=1 → count stays 1, and every output is the entry pushed one cycle earlier.
6. Assert reset mid-stream with count=3 and flush=1 simultaneously → count=0 and pointers 0. The next push/pop sequence behaves as after a power-on reset.
